// File: rtl/project_io_exerciser_if.sv
// Signal bundle between a test controller and project_io_exerciser: run control,
// status, signature readback and the pins of the project under test.
interface project_io_exerciser_if #(
  parameter int SETTLE_W = 4
) ();
  logic                start;
  logic                abort;
  logic [7:0]          pattern_len;
  logic [7:0]          seed;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                active;
  logic [7:0]          io_in;
  logic [7:0]          io_out;
  logic                busy;
  logic                done;
  logic [15:0]         signature;
  logic [7:0]          sample_count;

  modport master (
    output start, abort, pattern_len, seed, settle_cycles, io_out,
    input  active, io_in, busy, done, signature, sample_count
  );

  modport slave (
    input  start, abort, pattern_len, seed, settle_cycles, io_out,
    output active, io_in, busy, done, signature, sample_count
  );
endinterface

// File: rtl/project_io_exerciser.sv
// Drives LFSR vectors into a project under test, waits a settle time, and folds the
// sampled responses into a 16-bit MISR signature.
module project_io_exerciser #(
  parameter int SETTLE_W = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  project_io_exerciser_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [SETTLE_W-1:0] SETTLE_ZERO = SETTLE_W'(1'b0);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1'b1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [7:0]          len_r;
  logic [7:0]          lfsr_r;
  logic [7:0]          count_r;
  logic [7:0]          io_in_r;
  logic [SETTLE_W-1:0] settle_r;
  logic [SETTLE_W-1:0] wait_r;
  logic [15:0]         sig_r;
  logic                active_r;
  logic                busy_r;
  logic                done_r;
  logic                accept_s;
  logic [7:0]          count_inc_s;
  logic [7:0]          drive_val_s;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {8'h00, d};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  assign accept_s    = bus.start & ~bus.abort;
  assign count_inc_s = count_r + 8'd1;

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort wins over every other transition outside IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (bus.pattern_len == 8'd0) ? ST_DONE : ST_DRIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (settle_r != SETTLE_ZERO) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_SAMPLE;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (wait_r == SETTLE_ZERO) begin
          state_nxt_s = ST_SAMPLE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (count_inc_s == len_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Vector presented on entry to DRIVE: the fresh seed from IDLE, the advanced LFSR after SAMPLE.
  always_comb begin
    drive_val_s = lfsr_r;
    if (state_r == ST_SAMPLE) begin
      drive_val_s = lfsr_step(lfsr_r);
    end else if (state_r == ST_IDLE) begin
      drive_val_s = seed_fix(bus.seed);
    end else begin
      drive_val_s = lfsr_r;
    end
  end

  // Run datapath: latched parameters, LFSR, settle counter, signature and sample count.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      len_r    <= 8'h00;
      settle_r <= SETTLE_ZERO;
      wait_r   <= SETTLE_ZERO;
      lfsr_r   <= 8'h01;
      sig_r    <= 16'h0000;
      count_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            len_r    <= bus.pattern_len;
            settle_r <= bus.settle_cycles;
            lfsr_r   <= seed_fix(bus.seed);
            sig_r    <= 16'h0000;
            count_r  <= 8'h00;
          end
        end
        ST_DRIVE: begin
          wait_r <= settle_r - SETTLE_ONE;
        end
        ST_SETTLE: begin
          if (wait_r != SETTLE_ZERO) begin
            wait_r <= wait_r - SETTLE_ONE;
          end
        end
        ST_SAMPLE: begin
          if (!bus.abort) begin
            sig_r   <= misr_step(sig_r, bus.io_out);
            lfsr_r  <= lfsr_step(lfsr_r);
            count_r <= count_inc_s;
          end
        end
        default: begin
          wait_r <= wait_r;
        end
      endcase
    end
  end

  // Registered outputs, decoded from the state being entered so they line up with it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      active_r <= 1'b0;
      io_in_r  <= 8'h00;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_nxt_s == ST_DONE);
      case (state_nxt_s)
        ST_DRIVE: begin
          active_r <= 1'b1;
          io_in_r  <= drive_val_s;
        end
        ST_SETTLE, ST_SAMPLE: begin
          active_r <= 1'b1;
          io_in_r  <= io_in_r;
        end
        default: begin
          active_r <= 1'b0;
          io_in_r  <= 8'h00;
        end
      endcase
    end
  end

  assign bus.active       = active_r;
  assign bus.io_in        = io_in_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.signature    = sig_r;
  assign bus.sample_count = count_r;

endmodule

// File: doc/project_io_exerciser.md
PROJECT_IO_EXERCISER -- requirements
Module: project_io_exerciser

Interface
REQ-001 The block SHALL have parameter SETTLE_W, default 4: width of the settle-cycle count.
REQ-002 wb_clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 wb_rst_i  input  1  reset; SHALL be asynchronous and active-high.
REQ-004 start  input  1  single-cycle request to run one test sequence.
REQ-005 abort  input  1  synchronous request to stop the current sequence.
REQ-006 pattern_len  input  8  number of vectors to apply; latched at start.
REQ-007 seed  input  8  LFSR seed; latched at start.
REQ-008 settle_cycles  input  SETTLE_W  wait cycles between drive and sample; latched at start.
REQ-009 active  output  1  enable to the project under test; high while vectors are applied.
REQ-010 io_in  output  8  stimulus vector to the project's io_in.
REQ-011 io_out  input  8  response from the project's io_out; sampled only in SAMPLE.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 signature  output  16  MISR of the sampled responses.
REQ-015 sample_count  output  8  number of vectors sampled in the current or last run.

Function
REQ-016 The FSM SHALL have the states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-017 In IDLE, start=1 with abort=0 SHALL:
- latch pattern_len, seed and settle_cycles;
- load the LFSR with seed, or 8'h01 if seed=0;
- clear signature and sample_count;
- go to DRIVE, or go to DONE if pattern_len=0.
REQ-018 DRIVE SHALL register io_in<=LFSR and active<=1, then go to SETTLE if latched settle_cycles>0, else go to SAMPLE.
REQ-019 SETTLE SHALL hold io_in for exactly settle_cycles cycles, then go to SAMPLE.
REQ-020 SAMPLE SHALL:
- capture io_out;
- set signature <= {sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]} XOR {8'h00, io_out};
- advance the LFSR: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]};
- increment sample_count.
REQ-021 After SAMPLE, the FSM SHALL go to DONE if the new sample_count equals latched pattern_len, else to DRIVE.
REQ-022 DONE SHALL last one cycle with done=1 and active=0, then go to IDLE.
REQ-023 Timing: start sampled at edge k SHALL give done=1 in cycle k+1+N*(2+S), where N=pattern_len and S=settle_cycles; pattern_len=0 SHALL give done at k+1.
REQ-024 active SHALL be high from the first DRIVE through the last SAMPLE, including DRIVE-to-DRIVE transitions.
REQ-025 io_in SHALL be 8'h00 whenever active=0.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 pattern_len=255 SHALL run 255 vectors; sample_count SHALL NOT wrap during a run.
REQ-028 abort=1 in any non-IDLE state SHALL, at the next edge:
- go to IDLE;
- clear active and io_in;
- hold signature and sample_count;
- not pulse done.
REQ-029 abort and start both high in IDLE: abort SHALL win and no run SHALL start.
REQ-030 signature and sample_count SHALL hold their values in IDLE until the next accepted start.
REQ-031 Changes to inputs latched at start SHALL NOT affect a run in progress.

Reset
REQ-032 wb_rst_i=1 SHALL immediately, without a clock edge, set:
- FSM to IDLE;
- active, done and busy to 0;
- io_in to 8'h00, signature to 16'h0000, sample_count to 8'h00, LFSR to 8'h01.
REQ-033 Assertion of reset mid-run SHALL abandon the run with no done pulse.
REQ-034 After reset deassertion, the block SHALL accept start on the first clock edge.

Verification
REQ-035 Loopback (io_out=io_in), seed=8'h01, pattern_len=1, settle=0 -> io_in=8'h01 for 2 cycles, done at k+3, signature=16'h0001, sample_count=1.
REQ-036 Same setup with pattern_len=2 -> second vector io_in=8'h02, signature=16'h0000, sample_count=2, done at k+5.
REQ-037 seed=8'h00, pattern_len=3, settle=5, io_out tied 8'hFF -> first io_in=8'h01, each vector held 7 cycles, done at k+22, sample_count=3.
REQ-038 pattern_len=0 -> done at k+1, active never high, signature=16'h0000.
REQ-039 abort in SETTLE of vector 2, then a second start during the following IDLE cycle -> active drops at the next edge, no done, sample_count=1 held; the second start is accepted and rerun results match REQ-036.
REQ-040 wb_rst_i pulsed asynchronously mid-SAMPLE -> all outputs reset before the next edge, no done pulse.
